// File: rtl/dk_audio_pkg.sv
// Shared audio types and I2S framing constants.
// Used by the sample FIFO and the I2S transmitter.
package dk_audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int I2S_SLOT_BITS   = 32;
  localparam int I2S_FRAME_BITS  = 64;
  localparam int I2S_SAMPLE_BITS = 16;

  // Serial bit for slot position p (0..31):
  // one-bit delay after the word-select edge,
  // then 16 sample bits MSB first, then zeros.
  function automatic logic slot_bit(
    input sample_t    s,
    input logic [4:0] p
  );
    logic [4:0] w_idx;
    w_idx = 5'd16 - p;
    if (p >= 5'd1 && p <= 5'd16)
      return s[w_idx[3:0]];
    return 1'b0;
  endfunction

endpackage

// File: rtl/dk_sample_fifo.sv
// Synchronous sample FIFO, pop-before-push:
// a push is accepted on a full FIFO when a pop happens on the same clk.
module dk_sample_fifo
  import dk_audio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_push,
  input  sample_t i_data,
  input  logic    i_pop,
  output sample_t o_data,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  sample_t    r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        w_do_pop;
  logic        w_do_push;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd[AW-1:0]];

  // Read/write pointers with a wrap bit for full/empty.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/dk_audio_i2s_tx.sv
// Mono sample FIFO feeding a Philips I2S transmitter (sample on both slots).
// Define DK_I2S_TX_STATS_EN to implement the saturating underrun counter.
module dk_audio_i2s_tx
  import dk_audio_pkg::*;
#(
  parameter int CLOCK_RATE  = 24576000,
  parameter int SAMPLE_RATE = 48000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        audio_clk_en,
  input  sample_t     in,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        overflow,
  output logic        underrun,
  output logic [15:0] underrun_count
);

  localparam int HALF_BCLK = CLOCK_RATE / (SAMPLE_RATE * 128);
  localparam int DW = (HALF_BCLK > 1) ? $clog2(HALF_BCLK) : 1;

  generate
    if ((CLOCK_RATE % (SAMPLE_RATE * 128)) != 0 || HALF_BCLK < 2)
    begin : g_bad_rate
      $error("HALF_BCLK must be an integer >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [DW-1:0] r_div;
  logic [5:0]    r_bit;
  sample_t       r_hold;
  logic          r_bclk;
  logic          r_lrclk;
  logic          r_sdata;
  logic          r_ovf;
  logic          r_unr;

  logic          w_div_wrap;
  logic          w_fall;
  logic [5:0]    w_next_bit;
  logic          w_frame_start;
  logic          w_pop;
  sample_t       w_fifo_data;
  logic          w_full;
  logic          w_empty;

  assign w_div_wrap    = (r_div == DW'(HALF_BCLK - 1));
  assign w_fall        = w_div_wrap && r_bclk;
  assign w_next_bit    = r_bit + 6'd1;
  assign w_frame_start = w_fall && (w_next_bit == 6'd0);
  assign w_pop         = w_frame_start && !w_empty;

  dk_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (audio_clk_en),
    .i_data  (in),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Bit clock divider: toggle bclk each time the half-period count wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_div_wrap) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

  // Frame sequencing on bclk falling edges: bit index, word select, data, hold pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit   <= 6'd63;
      r_lrclk <= 1'b1;
      r_sdata <= 1'b0;
      r_hold  <= '0;
    end else if (w_fall) begin
      r_bit   <= w_next_bit;
      r_sdata <= slot_bit(r_hold, w_next_bit[4:0]);
      if (w_next_bit == 6'd0) begin
        r_lrclk <= 1'b0;
        if (!w_empty) r_hold <= w_fifo_data;
      end else if (w_next_bit == 6'd32) begin
        r_lrclk <= 1'b1;
      end
    end
  end

  // Sticky error flags: dropped push, frame started with nothing queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unr <= 1'b0;
    end else begin
      if (audio_clk_en && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_frame_start && w_empty)         r_unr <= 1'b1;
    end
  end

`ifdef DK_I2S_TX_STATS_EN
  logic [15:0] r_unr_cnt;

  // Saturating count of frames started with an empty FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_unr_cnt <= 16'd0;
    end else if (w_frame_start && w_empty && r_unr_cnt != 16'hFFFF) begin
      r_unr_cnt <= r_unr_cnt + 16'd1;
    end
  end

  assign underrun_count = r_unr_cnt;
`else
  assign underrun_count = 16'd0;
`endif

  assign i2s_bclk  = r_bclk;
  assign i2s_lrclk = r_lrclk;
  assign i2s_sdata = r_sdata;
  assign overflow  = r_ovf;
  assign underrun  = r_unr;

endmodule

// File: tb/tb_dk_audio_i2s_tx.sv
// Bench for dk_audio_i2s_tx: I2S receiver model decodes frames,
// table-driven stream plus directed overflow/underrun/reset sequences.
module tb_dk_audio_i2s_tx;

`ifdef DK_I2S_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        audio_clk_en = 1'b0;
  logic [15:0] in = 16'd0;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        overflow;
  logic        underrun;
  logic [15:0] underrun_count;

  dk_audio_i2s_tx dut (
    .clk            (clk),
    .reset          (reset),
    .audio_clk_en   (audio_clk_en),
    .in             (in),
    .i2s_bclk       (i2s_bclk),
    .i2s_lrclk      (i2s_lrclk),
    .i2s_sdata      (i2s_sdata),
    .overflow       (overflow),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        junk;
    logic        unr;
    logic [15:0] cnt;
  } frame_t;

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic        exp_unr;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  frame_t fq[$];
  int     mon_pos = 0;
  bit     mon_inf = 0;
  int     cyc = 0;
  int     last_lr = 0;
  int     last_b = 0;
  bit     have_lr = 0;
  bit     have_b = 0;
  int     lr_per_bad = 0;
  int     b_per_bad = 0;

  // DAC-side receiver: sample sdata on bclk rising, frame on lrclk falling.
  initial begin
    logic [63:0] bits;
    logic        pb;
    logic        pl;
    logic        lr_bad;
    frame_t      cur;
    bits = '0;
    pb = 1'b0;
    pl = 1'b1;
    lr_bad = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        mon_inf = 0;
        mon_pos = 0;
        pb = 1'b0;
        pl = 1'b1;
        have_lr = 0;
        have_b = 0;
      end else begin
        if (pl && !i2s_lrclk) begin
          if (have_lr && (cyc - last_lr) != 512) lr_per_bad++;
          have_lr = 1;
          last_lr = cyc;
          mon_inf = 1;
          mon_pos = 0;
          lr_bad = 1'b0;
          cur.unr = underrun;
          cur.cnt = underrun_count;
        end
        if (!pb && i2s_bclk) begin
          if (have_b && (cyc - last_b) != 8) b_per_bad++;
          have_b = 1;
          last_b = cyc;
          if (mon_inf) begin
            bits[mon_pos] = i2s_sdata;
            if (i2s_lrclk != (mon_pos >= 32)) lr_bad = 1'b1;
            mon_pos++;
            if (mon_pos == 64) begin
              for (int j = 0; j < 16; j++) begin
                cur.l[15-j] = bits[1+j];
                cur.r[15-j] = bits[33+j];
              end
              cur.junk = bits[0] | bits[32] | (|bits[31:17]) |
                         (|bits[63:49]) | lr_bad;
              fq.push_back(cur);
              mon_inf = 0;
            end
          end
        end
        pb = i2s_bclk;
        pl = i2s_lrclk;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    audio_clk_en = 1'b0;
    repeat (3) @(negedge clk);
    fq.delete();
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    audio_clk_en = 1'b1;
    in = v;
    @(negedge clk);
    audio_clk_en = 1'b0;
  endtask

  task automatic get_frame(input string nm, output frame_t f);
    int k;
    k = 0;
    while (fq.size() == 0 && k < 1500) begin
      @(negedge clk);
      k++;
    end
    if (fq.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: frame timeout got none want one", nm);
      f = '0;
    end else begin
      f = fq.pop_front();
    end
  endtask

  task automatic chk_frame(input string nm, input logic [15:0] el,
                           input logic [15:0] er, input logic eu);
    frame_t f;
    get_frame(nm, f);
    chk({nm, " left"}, 32'(f.l), 32'(el));
    chk({nm, " right"}, 32'(f.r), 32'(er));
    chk({nm, " zero bits"}, 32'(f.junk), 32'd0);
    chk({nm, " underrun"}, 32'(f.unr), 32'(eu));
  endtask

  vec_t tbl[8];

  initial begin
    frame_t f;
    int     n;

    tbl[0] = '{16'h8001, 16'h8001, 16'h8001, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[4] = '{16'h5555, 16'h5555, 16'h5555, 1'b0};
    tbl[5] = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 1'b0};
    tbl[6] = '{16'h0001, 16'h0001, 16'h0001, 1'b0};
    tbl[7] = '{16'h8000, 16'h8000, 16'h8000, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst bclk", 32'(i2s_bclk), 32'd0);
    chk("rst lrclk", 32'(i2s_lrclk), 32'd1);
    chk("rst sdata", 32'(i2s_sdata), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst underrun", 32'(underrun), 32'd0);
    chk("rst count", 32'(underrun_count), 32'd0);

    // single sample, then underrun repeats it
    do_reset();
    push(16'h8001);
    chk_frame("t1 f1", 16'h8001, 16'h8001, 1'b0);
    chk_frame("t1 f2", 16'h8001, 16'h8001, 1'b1);
    chk("t1 count", 32'(underrun_count), STATS ? 32'd1 : 32'd0);
    chk("t1 overflow", 32'(overflow), 32'd0);

    // no pushes: silent frames, counting underruns
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      get_frame("t2", f);
      chk("t2 left", 32'(f.l), 32'd0);
      chk("t2 right", 32'(f.r), 32'd0);
      chk("t2 underrun", 32'(f.unr), 32'd1);
      chk("t2 count", 32'(f.cnt), STATS ? 32'(i) : 32'd0);
    end

    // six back-to-back pushes into a 4-deep FIFO
    do_reset();
    for (int i = 1; i <= 6; i++) push(16'(i * 16'h1111));
    chk("t3 overflow", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++)
      chk_frame("t3 f", 16'(i * 16'h1111), 16'(i * 16'h1111), 1'b0);
    chk_frame("t3 repeat", 16'h4444, 16'h4444, 1'b1);

    // full FIFO, push coincides with the frame-start pop
    do_reset();
    for (int i = 1; i <= 4; i++) push(16'(16'hB000 + i));
    repeat (3) @(negedge clk);
    push(16'hB005);
    chk("t4 overflow", 32'(overflow), 32'd0);
    for (int i = 1; i <= 5; i++)
      chk_frame("t4 f", 16'(16'hB000 + i), 16'(16'hB000 + i), 1'b0);
    chk_frame("t4 repeat", 16'hB005, 16'hB005, 1'b1);
    chk("t4 overflow end", 32'(overflow), 32'd0);

    // reset at bit index 40 aborts the frame and empties the FIFO
    do_reset();
    push(16'hA5A5);
    push(16'h3C3C);
    n = 0;
    while (!(mon_inf && mon_pos == 41) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t5 reach bit40", 32'(n < 1000), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5 bclk", 32'(i2s_bclk), 32'd0);
    chk("t5 lrclk", 32'(i2s_lrclk), 32'd1);
    chk("t5 sdata", 32'(i2s_sdata), 32'd0);
    fq.delete();
    reset = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!i2s_lrclk) begin
        n = i;
        break;
      end
    end
    chk("t5 restart clks", 32'(n), 32'd8);
    chk_frame("t5 empty", 16'h0000, 16'h0000, 1'b1);

    // table-driven stream, one sample per frame
    do_reset();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          push(tbl[i].din);
          repeat (511) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 8; i++)
          chk_frame("tbl", tbl[i].exp_l, tbl[i].exp_r, tbl[i].exp_unr);
      end
    join

    // steady strobes: no flags, exact frame and bit clock periods
    do_reset();
    lr_per_bad = 0;
    b_per_bad = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          push(16'(i * 977 + 5));
          repeat (511) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          get_frame("t6", f);
          if (f.l !== 16'(i * 977 + 5) || f.r !== 16'(i * 977 + 5)) begin
            n_err++;
            $display("FAIL t6 data %0d: got %h/%h want %h", i, f.l, f.r,
                     16'(i * 977 + 5));
          end
          n_chk++;
        end
      end
    join
    chk("t6 overflow", 32'(overflow), 32'd0);
    chk("t6 underrun", 32'(underrun), 32'd0);
    chk("t6 lrclk period", 32'(lr_per_bad), 32'd0);
    chk("t6 bclk period", 32'(b_per_bad), 32'd0);
    chk("t6 count", 32'(underrun_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
